decode_cycle: RTL and testbench
===============================

Name: decode_cycle

Overview:
- Second pipeline stage. Consumes instrD, PCD and PCplus4D from the fetch stage.
- Decodes the instruction, reads the 32x32 integer register file, sign-extends the immediate, and registers everything into the D→E pipeline register feeding execute.
- Holds the architectural register file. Writeback writes it through this block's write port.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, register count; register 0 is hardwired to zero

Ports:
- clk  input  1  stage clock; all state updates on posedge clk
- rst  input  1  synchronous, active-high reset
- instrD  input  32  instruction from fetch (all-zero = bubble)
- PCD  input  32  PC of instrD
- PCplus4D  input  32  next-PC of instrD
- FlushE  input  1  high = load a bubble into the D→E register this edge
- RegWriteW  input  1  writeback register write enable
- RDW  input  5  writeback destination register
- ResultW  input  32  writeback data
- RegWriteE  output  1  registered: write rd in writeback
- ResultSrcE  output  1  registered: 0 = ALU result, 1 = memory load data
- MemWriteE  output  1  registered: store
- BranchE  output  1  registered: beq
- ALUSrcE  output  1  registered: 0 = RD2, 1 = ImmExt
- ALUControlE  output  3  registered: 000 add, 001 sub, 010 and, 011 or, 101 slt
- IllegalE  output  1  registered: unsupported non-zero encoding
- RD1E, RD2E  output  32  registered: rs1/rs2 operand values
- ImmExtE  output  32  registered: sign-extended immediate
- RS1E, RS2E, RDE  output  5  registered: instr[19:15], [24:20], [11:7]
- PCE, PCplus4E  output  32  registered: copies of PCD, PCplus4D

Behaviour:
- Latency: exactly one cycle, instrD at edge N → E outputs after edge N. No internal stall.
- Reset (rst=1 at posedge): all E outputs = 0; all 32 registers = 0. rst has priority over FlushE and over a register write in the same cycle.
- FlushE=1 (rst=0): all E outputs = 0 next cycle. The register-file write in that same cycle still happens.

Register file:
- Write at posedge when RegWriteW=1 and RDW≠0. Writes to x0 are discarded; x0 always reads 0.
- Reads are combinational on rs1/rs2 with write-through: if RegWriteW=1, RDW≠0 and RDW==rs, the read value is ResultW.

Decoder (instrD[6:0]):
- 0000011 lw: RegWrite=1, ResultSrc=1, ALUSrc=1, ALUControl=add, I-imm.
- 0100011 sw: MemWrite=1, ALUSrc=1, ALUControl=add, S-imm.
- 0110011 R-type, selected by funct3/funct7[5]:
  - 000/0 add
  - 000/1 sub
  - 111 and
  - 110 or
  - 010 slt
  - RegWrite=1, ALUSrc=0
- 0010011 I-ALU, funct3 000 addi / 111 andi / 110 ori / 010 slti: RegWrite=1, ALUSrc=1, I-imm.
- 1100011 with funct3=000 beq: Branch=1, ALUControl=sub, B-imm.
- instrD == 0: all controls 0, IllegalE=0 (bubble).
- Any other encoding, or an unsupported funct3/funct7 under a known opcode: all controls 0, IllegalE=1.

Immediates (bit 31 is always the sign bit):
- I: instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
- R-type / bubble / illegal: ImmExt=0.
- Branch-target arithmetic is performed in execute, not here.

Test Plan:
- rst=1 for 2 cycles with RegWriteW=1, RDW=3 → all E outputs 0; x3 still reads 0 after rst drops.
- Preload x8=0x100 via writeback. Then instrD=0x02842903 (lw s2,40(s0)) → RegWriteE=1, ResultSrcE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=0x28, RD1E=0x100, RDE=18.
- instrD=0x01AC89B3 (add s3,s9,s10) → ALUControlE=000, ALUSrcE=0, RS1E=25, RS2E=26, RDE=19. Then instrD=0x41830A33 (sub) → ALUControlE=001.
- instrD=0x016EAA23 (sw s6,20(t4)) → MemWriteE=1, RegWriteE=0, ImmExtE=0x14. instrD=0xFE000CE3 (beq x0,x0,-8) → BranchE=1, ImmExtE=0xFFFFFFF8, ALUControlE=001.
- Write-through: same cycle RegWriteW=1, RDW=5, ResultW=0xDEADBEEF, instrD reads rs1=x5 → RD1E=0xDEADBEEF. With RDW=0 instead → x0 read stays 0.
- FlushE=1 with a valid add in instrD → all E outputs 0. instrD=0 → IllegalE=0. instrD=0xFFFFFFFF → IllegalE=1, all controls 0.

Source files
------------

// File: rtl/decode_cycle.sv
// decode_cycle: second pipeline stage.
// Decodes the fetched instruction, reads the architectural register file with
// write-through from writeback, builds the sign-extended immediate, and
// registers everything into the D->E pipeline register feeding execute.
module decode_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCplus4D,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  output logic            RegWriteE,
  output logic            ResultSrcE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [2:0]      ALUControlE,
  output logic            IllegalE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      RS1E,
  output logic [4:0]      RS2E,
  output logic [4:0]      RDE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCplus4E
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2,
    IMM_B    = 2'd3
  } imm_sel_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode    = instrD[6:0];
  assign funct3    = instrD[14:12];
  assign funct7_b5 = instrD[30];
  assign rs1       = instrD[19:15];
  assign rs2       = instrD[24:20];
  assign rd        = instrD[11:7];

  // Architectural register file; entry 0 is never written outside reset
  logic [XLEN-1:0] regs [NREGS];

  // Decoded controls (combinational, registered below)
  logic     reg_write;
  logic     result_src;
  logic     mem_write;
  logic     branch;
  logic     alu_src;
  logic     illegal;
  alu_op_t  alu_control;
  imm_sel_t imm_sel;

  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] imm_ext;

  // Register file update: reset clears every entry and wins over writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWriteW && (RDW != 5'd0)) begin
      regs[RDW] <= ResultW;
    end
  end

  // Operand reads: x0 is hardwired zero, same-cycle writeback is forwarded
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != 5'd0) begin
      if (RegWriteW && (RDW == rs1)) begin
        rd1 = ResultW;
      end else begin
        rd1 = regs[rs1];
      end
    end
    if (rs2 != 5'd0) begin
      if (RegWriteW && (RDW == rs2)) begin
        rd2 = ResultW;
      end else begin
        rd2 = regs[rs2];
      end
    end
  end

  // Main decoder: unsupported encodings raise illegal with every control low
  always_comb begin
    reg_write   = 1'b0;
    result_src  = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    alu_src     = 1'b0;
    illegal     = 1'b0;
    alu_control = ALU_ADD;
    imm_sel     = IMM_NONE;
    case (opcode)
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          reg_write  = 1'b1;
          result_src = 1'b1;
          alu_src    = 1'b1;
          imm_sel    = IMM_I;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
          imm_sel   = IMM_S;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_RTYPE: begin
        case (funct3)
          3'b000: begin
            reg_write   = 1'b1;
            alu_control = funct7_b5 ? ALU_SUB : ALU_ADD;
          end
          3'b111: begin
            reg_write   = 1'b1;
            alu_control = ALU_AND;
          end
          3'b110: begin
            reg_write   = 1'b1;
            alu_control = ALU_OR;
          end
          3'b010: begin
            reg_write   = 1'b1;
            alu_control = ALU_SLT;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_IALU: begin
        case (funct3)
          3'b000: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = ALU_ADD;
            imm_sel     = IMM_I;
          end
          3'b111: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = ALU_AND;
            imm_sel     = IMM_I;
          end
          3'b110: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = ALU_OR;
            imm_sel     = IMM_I;
          end
          3'b010: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = ALU_SLT;
            imm_sel     = IMM_I;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          branch      = 1'b1;
          alu_control = ALU_SUB;
          imm_sel     = IMM_B;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = (instrD != 32'd0);
    endcase
  end

  // Immediate generation; bit 31 always supplies the sign
  always_comb begin
    imm_ext = '0;
    case (imm_sel)
      IMM_I:   imm_ext = {{(XLEN-12){instrD[31]}}, instrD[31:20]};
      IMM_S:   imm_ext = {{(XLEN-12){instrD[31]}}, instrD[31:25], instrD[11:7]};
      IMM_B:   imm_ext = {{(XLEN-13){instrD[31]}}, instrD[31], instrD[7],
                          instrD[30:25], instrD[11:8], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // D->E pipeline register: reset or flush loads a bubble
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= 3'b000;
      IllegalE    <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      RS1E        <= 5'd0;
      RS2E        <= 5'd0;
      RDE         <= 5'd0;
      PCE         <= '0;
      PCplus4E    <= '0;
    end else begin
      RegWriteE   <= reg_write;
      ResultSrcE  <= result_src;
      MemWriteE   <= mem_write;
      BranchE     <= branch;
      ALUSrcE     <= alu_src;
      ALUControlE <= alu_control;
      IllegalE    <= illegal;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      RS1E        <= rs1;
      RS2E        <= rs2;
      RDE         <= rd;
      PCE         <= PCD;
      PCplus4E    <= PCplus4D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed and randomized checks of decode_cycle against a
// mnemonic-level reference model with a shadow register file.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic [31:0] PCplus4D;
  logic        FlushE;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        RegWriteE;
  logic        ResultSrcE;
  logic        MemWriteE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic        IllegalE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [4:0]  RS1E;
  logic [4:0]  RS2E;
  logic [4:0]  RDE;
  logic [31:0] PCE;
  logic [31:0] PCplus4E;

  int vector_count = 0;
  int fail_count   = 0;

  logic [31:0] model_regs [32];

  typedef enum {
    M_BUBBLE, M_ILLEGAL, M_LW, M_SW, M_ADD, M_SUB, M_AND, M_OR, M_SLT,
    M_ADDI, M_ANDI, M_ORI, M_SLTI, M_BEQ
  } mnem_t;

  typedef struct {
    logic        reg_write;
    logic        result_src;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    logic        illegal;
    logic [2:0]  alu_control;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  decode_cycle #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .instrD(instrD), .PCD(PCD), .PCplus4D(PCplus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .IllegalE(IllegalE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE), .PCE(PCE), .PCplus4E(PCplus4E)
  );

  always #5 clk = ~clk;

  // Name the instruction the way an assembler listing would
  function automatic mnem_t mnemonic(input logic [31:0] ins);
    int op = int'(ins[6:0]);
    int f3 = int'(ins[14:12]);
    if (ins == 32'd0) return M_BUBBLE;
    if (op == 'h03) return (f3 == 2) ? M_LW : M_ILLEGAL;
    if (op == 'h23) return (f3 == 2) ? M_SW : M_ILLEGAL;
    if (op == 'h33) begin
      if (f3 == 0) return ins[30] ? M_SUB : M_ADD;
      if (f3 == 7) return M_AND;
      if (f3 == 6) return M_OR;
      if (f3 == 2) return M_SLT;
      return M_ILLEGAL;
    end
    if (op == 'h13) begin
      if (f3 == 0) return M_ADDI;
      if (f3 == 7) return M_ANDI;
      if (f3 == 6) return M_ORI;
      if (f3 == 2) return M_SLTI;
      return M_ILLEGAL;
    end
    if (op == 'h63) return (f3 == 0) ? M_BEQ : M_ILLEGAL;
    return M_ILLEGAL;
  endfunction

  function automatic logic [2:0] alu_of(input mnem_t m);
    case (m)
      M_SUB, M_BEQ:   return 3'd1;
      M_AND, M_ANDI:  return 3'd2;
      M_OR, M_ORI:    return 3'd3;
      M_SLT, M_SLTI:  return 3'd5;
      default:        return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    int v = $signed(ins) >>> 20;
    return v;
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    int hi = $signed(ins) >>> 25;
    return hi * 32 + int'(ins[11:7]);
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    int v = ins[31] ? -4096 : 0;
    v = v + (ins[7] ? 2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    return v;
  endfunction

  function automatic logic [31:0] read_ref(input logic [4:0] rs, input logic we,
                                           input logic [4:0] rdw, input logic [31:0] res);
    if (rs == 5'd0) return 32'd0;
    if (we && rdw == rs) return res;
    return model_regs[rs];
  endfunction

  function automatic exp_t predict(input logic r, input logic f, input logic [31:0] ins,
                                   input logic [31:0] pc, input logic we,
                                   input logic [4:0] rdw, input logic [31:0] res);
    exp_t  e = '{default: '0};
    mnem_t m = mnemonic(ins);
    if (r || f) return e;
    case (m)
      M_LW: begin
        e.reg_write = 1; e.result_src = 1; e.alu_src = 1; e.imm = imm_i(ins);
      end
      M_SW: begin
        e.mem_write = 1; e.alu_src = 1; e.imm = imm_s(ins);
      end
      M_ADD, M_SUB, M_AND, M_OR, M_SLT: e.reg_write = 1;
      M_ADDI, M_ANDI, M_ORI, M_SLTI: begin
        e.reg_write = 1; e.alu_src = 1; e.imm = imm_i(ins);
      end
      M_BEQ: begin
        e.branch = 1; e.imm = imm_b(ins);
      end
      M_ILLEGAL: e.illegal = 1;
      default: ;
    endcase
    e.alu_control = (m == M_ILLEGAL || m == M_BUBBLE) ? 3'd0 : alu_of(m);
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.rd1 = read_ref(ins[19:15], we, rdw, res);
    e.rd2 = read_ref(ins[24:20], we, rdw, res);
    e.pc  = pc;
    e.pc4 = pc + 32'd4;
    return e;
  endfunction

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vector_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check every E output
  task automatic applyStimulus(input string tag, input logic r, input logic f,
                               input logic [31:0] ins, input logic [31:0] pc,
                               input logic we, input logic [4:0] rdw,
                               input logic [31:0] res);
    exp_t e;
    rst = r; FlushE = f; instrD = ins; PCD = pc; PCplus4D = pc + 32'd4;
    RegWriteW = we; RDW = rdw; ResultW = res;
    e = predict(r, f, ins, pc, we, rdw, res);
    if (r) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (we && rdw != 5'd0) begin
      model_regs[rdw] = res;
    end
    @(posedge clk);
    #1;
    checkOutput({tag, ".RegWriteE"},   RegWriteE,   e.reg_write);
    checkOutput({tag, ".ResultSrcE"},  ResultSrcE,  e.result_src);
    checkOutput({tag, ".MemWriteE"},   MemWriteE,   e.mem_write);
    checkOutput({tag, ".BranchE"},     BranchE,     e.branch);
    checkOutput({tag, ".ALUSrcE"},     ALUSrcE,     e.alu_src);
    checkOutput({tag, ".ALUControlE"}, ALUControlE, e.alu_control);
    checkOutput({tag, ".IllegalE"},    IllegalE,    e.illegal);
    checkOutput({tag, ".RD1E"},        RD1E,        e.rd1);
    checkOutput({tag, ".RD2E"},        RD2E,        e.rd2);
    checkOutput({tag, ".ImmExtE"},     ImmExtE,     e.imm);
    checkOutput({tag, ".RS1E"},        RS1E,        e.rs1);
    checkOutput({tag, ".RS2E"},        RS2E,        e.rs2);
    checkOutput({tag, ".RDE"},         RDE,         e.rd);
    checkOutput({tag, ".PCE"},         PCE,         e.pc);
    checkOutput({tag, ".PCplus4E"},    PCplus4E,    e.pc4);
  endtask

  // Random instruction biased towards supported encodings
  function automatic logic [31:0] rand_instr();
    logic [31:0] r    = $urandom;
    int          kind = $urandom_range(0, 9);
    int          pick = $urandom_range(0, 4);
    logic [2:0]  good;
    case (pick)
      0: good = 3'b000;
      1: good = 3'b111;
      2: good = 3'b110;
      3: good = 3'b010;
      default: good = 3'($urandom_range(0, 7));
    endcase
    case (kind)
      0: begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
      1: begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
      2, 3: begin
        r[6:0] = 7'b0110011; r[14:12] = good;
        r[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
      end
      4: begin r[6:0] = 7'b0010011; r[14:12] = good; end
      5: begin
        r[6:0] = 7'b1100011;
        if ($urandom_range(0, 1) == 1) r[14:12] = 3'b000;
      end
      6: r = 32'd0;
      default: begin
        if (r[6:0] == 7'b0000011 || r[6:0] == 7'b0100011) r[14:12] = 3'b010;
      end
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] pc = 32'h0000_1000;
    rst = 1'b1; FlushE = 1'b0; instrD = '0; PCD = '0; PCplus4D = '0;
    RegWriteW = 1'b0; RDW = '0; ResultW = '0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    // Reset with a competing write to x3
    applyStimulus("rst0", 1, 0, 32'h003180B3, 32'h100, 1, 5'd3, 32'h1234_5678);
    applyStimulus("rst1", 1, 0, 32'h003180B3, 32'h104, 1, 5'd3, 32'h1234_5678);
    applyStimulus("x3_after_rst", 0, 0, 32'h003180B3, 32'h108, 0, 5'd0, 32'd0);
    checkOutput("x3_zero", RD1E, 32'd0);

    // Preload x8 then lw s2,40(s0)
    applyStimulus("preload_x8", 0, 0, 32'd0, 32'h10C, 1, 5'd8, 32'h100);
    applyStimulus("lw", 0, 0, 32'h02842903, 32'h110, 0, 5'd0, 32'd0);
    checkOutput("lw.imm_const", ImmExtE, 32'h28);
    checkOutput("lw.rd1_const", RD1E, 32'h100);
    checkOutput("lw.rd_const", RDE, 32'd18);

    applyStimulus("add", 0, 0, 32'h01AC89B3, 32'h114, 0, 5'd0, 32'd0);
    applyStimulus("sub", 0, 0, 32'h41830A33, 32'h118, 0, 5'd0, 32'd0);
    checkOutput("sub.alu_const", ALUControlE, 32'd1);
    applyStimulus("sw", 0, 0, 32'h016EAA23, 32'h11C, 0, 5'd0, 32'd0);
    checkOutput("sw.imm_const", ImmExtE, 32'h14);
    applyStimulus("beq", 0, 0, 32'hFE000CE3, 32'h120, 0, 5'd0, 32'd0);
    checkOutput("beq.imm_const", ImmExtE, 32'hFFFF_FFF8);

    // Write-through on x5, and a write to x0 that must be dropped
    applyStimulus("wt_x5", 0, 0, 32'h00028093, 32'h124, 1, 5'd5, 32'hDEAD_BEEF);
    checkOutput("wt_x5.rd1_const", RD1E, 32'hDEAD_BEEF);
    applyStimulus("wt_x0", 0, 0, 32'h000000B3, 32'h128, 1, 5'd0, 32'h0000_55AA);
    checkOutput("wt_x0.rd1_const", RD1E, 32'd0);

    // Flush with a valid add, while writeback lands in x9
    applyStimulus("flush", 0, 1, 32'h01AC89B3, 32'h12C, 1, 5'd9, 32'hCAFE_0009);
    applyStimulus("x9_after_flush", 0, 0, 32'h000480B3, 32'h130, 0, 5'd0, 32'd0);
    checkOutput("x9_kept", RD1E, 32'hCAFE_0009);

    applyStimulus("bubble", 0, 0, 32'd0, 32'h134, 0, 5'd0, 32'd0);
    applyStimulus("all_ones", 0, 0, 32'hFFFF_FFFF, 32'h138, 0, 5'd0, 32'd0);
    checkOutput("all_ones.illegal_const", IllegalE, 32'd1);
    applyStimulus("sll_illegal", 0, 0, 32'h002091B3, 32'h13C, 0, 5'd0, 32'd0);
    applyStimulus("bne_illegal", 0, 0, 32'h00209463, 32'h140, 0, 5'd0, 32'd0);
    applyStimulus("lb_illegal", 0, 0, 32'h00040903, 32'h144, 0, 5'd0, 32'd0);

    // Randomized traffic with occasional flushes and resets
    for (int n = 0; n < 400; n++) begin
      logic        r   = ($urandom_range(0, 99) < 2);
      logic        f   = ($urandom_range(0, 99) < 10);
      logic        we  = ($urandom_range(0, 1) == 1);
      logic [4:0]  rdw = 5'($urandom_range(0, 31));
      logic [31:0] res = $urandom;
      applyStimulus("rand", r, f, rand_instr(), pc, we, rdw, res);
      pc = pc + 32'd4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, fail_count);
    $finish;
  end

endmodule
